// File: rtl/rect_clamp_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rect_pkg
// Shared types and default dimensions for the rectangle clamp pipeline.
//   rect_in_t  : four signed input coordinates {x0, y0, x1, y1}, x0 in MSBs
//   rect_out_t : four unsigned clamped coordinates, same field order
// The struct widths use the default coordinate widths; modules that are
// re-parametrised work on flat vectors with the same field order.
// ---------------------------------------------------------------------------
package rect_pkg;

   localparam int DEF_COORD_W = 16;
   localparam int DEF_OUT_W   = 10;
   localparam int DEF_CNT_W   = 16;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;

   typedef struct packed {
      logic signed [DEF_COORD_W-1:0] x0;
      logic signed [DEF_COORD_W-1:0] y0;
      logic signed [DEF_COORD_W-1:0] x1;
      logic signed [DEF_COORD_W-1:0] y1;
   } rect_in_t;

   typedef struct packed {
      logic [DEF_OUT_W-1:0] x0;
      logic [DEF_OUT_W-1:0] y0;
      logic [DEF_OUT_W-1:0] x1;
      logic [DEF_OUT_W-1:0] y1;
   } rect_out_t;

endpackage

// File: rtl/rect_clamp_pipe_coord_clamp.sv
// ---------------------------------------------------------------------------
// coord_clamp
// Combinational clamp of one signed coordinate into [0, L].
// Ports:
//   i_c   : signed input coordinate (COORD_W bits, two's complement)
//   o_c   : clamped unsigned coordinate (OUT_W bits)
//   o_mod : clamped value differs from the input
// ---------------------------------------------------------------------------
module coord_clamp
   import rect_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int L       = SCREEN_W
) (
   input  logic signed [COORD_W-1:0] i_c,
   output logic        [OUT_W-1:0]   o_c,
   output logic                      o_mod
);

   localparam logic signed [COORD_W-1:0] LC   = COORD_W'(L);
   localparam logic        [OUT_W-1:0]   LOUT = OUT_W'(L);

   always_comb begin
      o_c   = '0;
      o_mod = 1'b0;
      if (i_c[COORD_W-1]) begin
         // any negative value is necessarily changed by forcing it to 0
         o_c   = '0;
         o_mod = 1'b1;
      end else if (i_c >= LC) begin
         // exactly L passes through unchanged and is not a clip
         o_c   = LOUT;
         o_mod = (i_c != LC);
      end else begin
         // 0 <= c < L < 2^OUT_W, so truncation loses nothing
         o_c   = i_c[OUT_W-1:0];
         o_mod = 1'b0;
      end
   end

endmodule

// File: rtl/rect_clamp_pipe.sv
// ---------------------------------------------------------------------------
// rect_clamp_pipe
// Two-stage pipelined rectangle clamp between rectangle fetch and the
// scanline rasteriser. Stage 1 clamps the four coordinates and flags any
// modification; stage 2 registers the zero-area flag and drives the output.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_rect = {x0,y0,x1,y1} signed
//   out_valid/out_ready   : output handshake, out_rect = clamped {x0,y0,x1,y1}
//   out_empty             : clamped rectangle has zero area
//   out_clipped           : at least one coordinate was modified
//   clip_cnt              : saturating count of emitted clipped rectangles
//   clr_cnt               : synchronous clear of the statistics counters
//   cull_cnt              : (RECT_CLAMP_CULL_EN only) saturating count of
//                           dropped empty rectangles
//
// Build option: define RECT_CLAMP_CULL_EN to drop empty rectangles in stage 2
// instead of emitting them; out_empty is then tied low.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Each
// stage advances when it is empty or its downstream stage advances; output
// data holds stable while out_valid && !out_ready, and out_valid only falls
// after a transfer.
// ---------------------------------------------------------------------------
module rect_clamp_pipe
   import rect_pkg::*;
#(
   parameter int COORD_W  = DEF_COORD_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int SCREEN_W = rect_pkg::SCREEN_W,
   parameter int SCREEN_H = rect_pkg::SCREEN_H,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*COORD_W-1:0] in_rect,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*OUT_W-1:0]   out_rect,
   output logic                 out_empty,
   output logic                 out_clipped,
   output logic [CNT_W-1:0]     clip_cnt,
`ifdef RECT_CLAMP_CULL_EN
   output logic [CNT_W-1:0]     cull_cnt,
`endif
   input  logic                 clr_cnt
);

   // ---------------- stage 1: clamp ----------------
   logic [4*OUT_W-1:0] w_clamped;
   logic [3:0]         w_mod;

   for (genvar k = 0; k < 4; k++) begin : g_clamp
      // even fields are X (x0, x1), odd fields are Y (y0, y1)
      coord_clamp #(
         .COORD_W (COORD_W),
         .OUT_W   (OUT_W),
         .L       ((k % 2 == 0) ? SCREEN_W : SCREEN_H)
      ) u_clamp (
         .i_c   (in_rect[(4-k)*COORD_W-1 -: COORD_W]),
         .o_c   (w_clamped[(4-k)*OUT_W-1 -: OUT_W]),
         .o_mod (w_mod[k])
      );
   end

   logic               r_s1_valid;
   logic [4*OUT_W-1:0] r_s1_rect;
   logic               r_s1_clip;

   // ---------------- stage 2 input: zero-area test ----------------
   logic [OUT_W-1:0] w_s1_x0, w_s1_y0, w_s1_x1, w_s1_y1;
   logic             w_s1_empty;

   assign w_s1_x0    = r_s1_rect[4*OUT_W-1 -: OUT_W];
   assign w_s1_y0    = r_s1_rect[3*OUT_W-1 -: OUT_W];
   assign w_s1_x1    = r_s1_rect[2*OUT_W-1 -: OUT_W];
   assign w_s1_y1    = r_s1_rect[OUT_W-1:0];
   // unsigned compare on clamped values; degenerate x0 > x1 lands here too
   assign w_s1_empty = (w_s1_x1 <= w_s1_x0) || (w_s1_y1 <= w_s1_y0);

   // ---------------- flow control ----------------
   logic w_s2_adv;
   logic w_s1_adv;
   logic w_s1_drop;
   logic w_out_xfer;

`ifdef RECT_CLAMP_CULL_EN
   // an empty rectangle is discarded from stage 1 without needing the
   // output register, so it never waits behind a stalled output
   assign w_s1_drop = r_s1_valid && w_s1_empty;
`else
   assign w_s1_drop = 1'b0;
`endif

   assign w_s2_adv   = !out_valid || out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv || w_s1_drop;
   assign in_ready   = w_s1_adv;
   assign w_out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_rect  <= '0;
         r_s1_clip  <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_rect <= w_clamped;
            r_s1_clip <= |w_mod;
         end
      end
   end

   // ---------------- stage 2: output register ----------------
   logic               r_out_valid;
   logic [4*OUT_W-1:0] r_out_rect;
   logic               r_out_clipped;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_rect    <= '0;
         r_out_clipped <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid && !w_s1_drop;
         if (r_s1_valid && !w_s1_drop) begin
            r_out_rect    <= r_s1_rect;
            r_out_clipped <= r_s1_clip;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_rect    = r_out_rect;
   assign out_clipped = r_out_clipped;

`ifdef RECT_CLAMP_CULL_EN
   assign out_empty = 1'b0;
`else
   logic r_out_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_empty <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         r_out_empty <= w_s1_empty;
      end
   end

   assign out_empty = r_out_empty;
`endif

   // ---------------- statistics ----------------
   logic [CNT_W-1:0] r_clip_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clip_cnt <= '0;
      end else if (clr_cnt) begin
         r_clip_cnt <= '0;
      end else if (w_out_xfer && r_out_clipped && (r_clip_cnt != '1)) begin
         r_clip_cnt <= r_clip_cnt + 1'b1;
      end
   end

   assign clip_cnt = r_clip_cnt;

`ifdef RECT_CLAMP_CULL_EN
   logic [CNT_W-1:0] r_cull_cnt;

   // w_s1_drop already implies stage 1 advances this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cull_cnt <= '0;
      end else if (clr_cnt) begin
         r_cull_cnt <= '0;
      end else if (w_s1_drop && (r_cull_cnt != '1)) begin
         r_cull_cnt <= r_cull_cnt + 1'b1;
      end
   end

   assign cull_cnt = r_cull_cnt;
`endif

endmodule

// File: tb/tb_rect_clamp_pipe.sv
// ---------------------------------------------------------------------------
// tb_rect_clamp_pipe
// Directed bench for rect_clamp_pipe (CNT_W=4). Expected output words are
// {x0,y0,x1,y1,empty,clipped} written by hand per vector and queued when
// the input transfer happens; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_rect_clamp_pipe;
   import rect_pkg::*;

   localparam int CW = 16;
   localparam int OW = 10;
   localparam int NW = 4;
`ifdef RECT_CLAMP_CULL_EN
   localparam bit CULL = 1'b1;
`else
   localparam bit CULL = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [4*CW-1:0] in_rect;
   logic            out_valid;
   logic            out_ready;
   logic [4*OW-1:0] out_rect;
   logic            out_empty;
   logic            out_clipped;
   logic [NW-1:0]   clip_cnt;
   logic            clr_cnt;
`ifdef RECT_CLAMP_CULL_EN
   logic [NW-1:0]   cull_cnt;
`endif

   rect_clamp_pipe #(
      .COORD_W  (CW),
      .OUT_W    (OW),
      .SCREEN_W (640),
      .SCREEN_H (480),
      .CNT_W    (NW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rect     (in_rect),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rect    (out_rect),
      .out_empty   (out_empty),
      .out_clipped (out_clipped),
      .clip_cnt    (clip_cnt),
`ifdef RECT_CLAMP_CULL_EN
      .cull_cnt    (cull_cnt),
`endif
      .clr_cnt     (clr_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;
   logic [4*OW+1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*CW-1:0] mk(input int a, input int b,
                                           input int c, input int d);
      rect_in_t r;
      r.x0 = CW'(a);
      r.y0 = CW'(b);
      r.x1 = CW'(c);
      r.y1 = CW'(d);
      return r;
   endfunction

   function automatic logic [4*OW+1:0] ex(input int a, input int b,
                                          input int c, input int d,
                                          input bit e, input bit cl);
      return {OW'(a), OW'(b), OW'(c), OW'(d), e, cl};
   endfunction

   // ---------------- driver ----------------
   task automatic send(input logic [4*CW-1:0] r, input logic [4*OW+1:0] e);
      int n;
      in_valid = 1'b1;
      in_rect  = r;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         check("send_timeout", 64'(n), 64'(0));
      end else begin
         // empty rectangles never come out when culling is built in
         if (!(CULL && e[1])) exp_q.push_back(e);
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   logic            hold_v = 1'b0;
   logic [4*OW+1:0] hold_w;

   always @(negedge clk) begin
      logic [4*OW+1:0] w;
      w = {out_rect, out_empty, out_clipped};
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) check("hold_stable", {63'(w), out_valid}, {63'(hold_w), 1'b1});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'(w), 64'(0));
            else check("out_word", 64'(w), 64'(exp_q.pop_front()));
         end
         if (out_valid && !out_ready) begin
            hold_v = 1'b1;
            hold_w = w;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [4*CW-1:0] bp_r[6];
   logic [4*OW+1:0] bp_e[6];
   bit              saw_stall;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_rect   = '0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;

      bp_r[0] = mk(10, 20, 30, 40);       bp_e[0] = ex(10, 20, 30, 40, 0, 0);
      bp_r[1] = mk(-3, 5, 60, 70);        bp_e[1] = ex(0, 5, 60, 70, 0, 1);
      bp_r[2] = mk(100, 100, 700, 500);   bp_e[2] = ex(100, 100, 640, 480, 0, 1);
      bp_r[3] = mk(1, 2, 3, 4);           bp_e[3] = ex(1, 2, 3, 4, 0, 0);
      bp_r[4] = mk(0, 0, 640, 480);       bp_e[4] = ex(0, 0, 640, 480, 0, 0);
      bp_r[5] = mk(200, 300, 1000, -20);  bp_e[5] = ex(200, 300, 640, 0, 1, 1);

      // reset state
      idle(3);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_word", 64'({out_rect, out_empty, out_clipped}), 64'(0));
      check("rst_clip_cnt", 64'(clip_cnt), 64'(0));
`ifdef RECT_CLAMP_CULL_EN
      check("rst_cull_cnt", 64'(cull_cnt), 64'(0));
`endif
      rst_n = 1'b1;
      idle(2);

      // negative clamp with latency check
      send(mk(-5, -1, 100, 50), ex(0, 0, 100, 50, 0, 1));
      @(negedge clk);
      check("lat_cycle1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("lat_cycle2", 64'(out_valid), 64'(1));
      idle(3);
      check("clip_cnt_neg", 64'(clip_cnt), 64'(1));

      // boundaries and empty detection, back to back
      send(mk(639, 479, 640, 480), ex(639, 479, 640, 480, 0, 0));
      send(mk(641, 481, 32'h7FFF, 32'h8000), ex(640, 480, 640, 0, 1, 1));
      send(mk(700, 10, 800, 20), ex(640, 10, 640, 20, 1, 1));
      idle(5);
      check("clip_cnt_bound", 64'(clip_cnt), CULL ? 64'(1) : 64'(3));
`ifdef RECT_CLAMP_CULL_EN
      check("cull_cnt_bound", 64'(cull_cnt), 64'(2));
`endif

      // backpressure: out_ready low for cycles 3..7 of the stream
      saw_stall = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(bp_r[i], bp_e[i]);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               if (in_valid && !in_ready) saw_stall = 1'b1;
            end
         end
      join
      idle(5);
      check("bp_in_ready_low", 64'(saw_stall), 64'(1));
      check("bp_drained", 64'(exp_q.size()), 64'(0));
      check("clip_cnt_bp", 64'(clip_cnt), CULL ? 64'(3) : 64'(6));
`ifdef RECT_CLAMP_CULL_EN
      check("cull_cnt_bp", 64'(cull_cnt), 64'(3));
`endif

      // saturation
      for (int i = 0; i < 20; i++) send(mk(-1, 0, 10, 10), ex(0, 0, 10, 10, 0, 1));
      idle(4);
      check("clip_cnt_sat", 64'(clip_cnt), 64'(15));

      // plain clear, then clear colliding with a clipped transfer
      clr_cnt = 1'b1;
      idle(1);
      clr_cnt = 1'b0;
      check("clip_cnt_clr", 64'(clip_cnt), 64'(0));
`ifdef RECT_CLAMP_CULL_EN
      check("cull_cnt_clr", 64'(cull_cnt), 64'(0));
`endif
      send(mk(-1, 0, 10, 10), ex(0, 0, 10, 10, 0, 1));
      idle(4);
      check("clip_cnt_one", 64'(clip_cnt), 64'(1));
      send(mk(-1, 0, 10, 10), ex(0, 0, 10, 10, 0, 1));
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!(out_valid && out_ready) && n < 20) begin
            n++;
            @(negedge clk);
         end
         check("clr_wait", 64'(n < 20), 64'(1));
         clr_cnt = 1'b1;
         @(posedge clk);
         #1 clr_cnt = 1'b0;
      end
      check("clip_cnt_clr_prio", 64'(clip_cnt), 64'(0));

      // async reset with two rectangles in flight
      out_ready = 1'b0;
      send(mk(5, 5, 50, 50), ex(5, 5, 50, 50, 0, 0));
      send(mk(6, 6, 60, 60), ex(6, 6, 60, 60, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(out_valid), 64'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      idle(8);
      check("no_stale_out", 64'(out_valid), 64'(0));
      check("rst_clip_cnt2", 64'(clip_cnt), 64'(0));

      // pipeline still works after reset
      send(mk(-7, 8, 900, 400), ex(0, 8, 640, 400, 0, 1));
      idle(5);
      check("final_drain", 64'(exp_q.size()), 64'(0));
      check("clip_cnt_final", 64'(clip_cnt), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rect_clamp_pipe.md
Name: rect_clamp_pipe

Overview:
- Pipelined, parametrised successor to the single-coordinate screen clamp.
- Accepts one rectangle per transfer: four signed coordinates x0, y0, x1, y1.
- Clamps X coordinates to [0, SCREEN_W] and Y coordinates to [0, SCREEN_H], flags zero-area results and counts clipped rectangles.
- Sits between the rectangle fetch logic and the scanline rasteriser, with valid/ready on both sides.

Parameters:
- COORD_W, 16, input coordinate width, two's complement.
- OUT_W, 10, output coordinate width, unsigned; must satisfy 2^OUT_W > max(SCREEN_W, SCREEN_H).
- SCREEN_W, 640, X upper bound (inclusive clamp value).
- SCREEN_H, 480, Y upper bound (inclusive clamp value).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input rectangle valid.
- in_ready  out  1  block accepts input this cycle.
- in_rect  in  4*COORD_W  {x0, y0, x1, y1}, x0 in MSBs.
- out_valid  out  1  output rectangle valid.
- out_ready  in  1  downstream accepts output.
- out_rect  out  4*OUT_W  clamped {x0, y0, x1, y1}.
- out_empty  out  1  clamped rectangle has zero area.
- out_clipped  out  1  at least one coordinate was modified.
- clip_cnt  out  CNT_W  saturating count of emitted clipped rectangles.
- clr_cnt  in  1  synchronous counter clear.

Behaviour:
- Reset values: out_valid=0, out_rect=0, out_empty=0, out_clipped=0, clip_cnt=0 (and cull_cnt=0 when present). Internal stage-valid bits are 0. in_ready may be 1 during reset.
- Clamp rule per coordinate c, bound L:
  - sign bit set -> 0.
  - c >= L, compared signed at COORD_W -> L.
  - otherwise -> c[OUT_W-1:0].
  - Exactly c==L yields L and is not counted as clipped.
- Stage 1 register: four clamped coordinates, plus clipped = OR over coordinates of (clamped value != original value).
- Stage 2 register: adds empty = (x1 <= x0) || (y1 <= y0), compared unsigned on clamped values.
- Latency: 2 cycles, in handshake to out_valid, when there is no backpressure.
- Throughput: 1 rectangle per cycle.
- Handshake:
  - Transfer occurs when valid && ready.
  - A stage advances when it is empty or the stage downstream advances.
  - in_ready = !s1_valid || s1_advance.
  - out_rect, out_empty and out_clipped hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Ordering: strict FIFO order; no reordering, no duplication.
- clip_cnt:
  - Increments on each output transfer with out_clipped=1.
  - Saturates at all-ones.
  - clr_cnt has priority over increment in the same cycle.
- Reset mid-operation: all in-flight rectangles are discarded, with no partial output.
- Degenerate input: x0 > x1 is not reordered; it is clamped independently and reported as empty.

Optional Feature:
- Macro: RECT_CLAMP_CULL_EN.
- Defined:
  - Stage 2 drops empty rectangles; out_valid is never asserted for them and they do not stall.
  - Adds output port cull_cnt, CNT_W wide: saturating count of dropped rectangles, also cleared by clr_cnt.
  - out_empty is tied to 0.
  - Latency of surviving rectangles is unchanged.
- Undefined:
  - All rectangles are emitted with out_empty reporting the flag.
  - No cull_cnt port.

Decomposition:
- Package rect_pkg:
  - typedef rect_in_t: packed struct of four signed COORD_W fields.
  - typedef rect_out_t: packed struct of four OUT_W fields.
  - Localparams SCREEN_W=640 and SCREEN_H=480 as defaults.
- Sub-module coord_clamp (COORD_W, OUT_W, L parameters):
  - Purely combinational.
  - Outputs the clamped value and a modified flag.
  - Instantiated four times: two with L=SCREEN_W, two with L=SCREEN_H.

Test Plan:
- Negative clamp: in_rect {-5, -1, 100, 50}, out_ready=1 -> after 2 cycles out_rect {0, 0, 100, 50}, out_clipped=1, out_empty=0, clip_cnt=1.
- Boundary: {639, 479, 640, 480} -> unchanged, out_clipped=0. {641, 481, 0x7FFF, 0x8000} -> {640, 480, 640, 0}, out_clipped=1.
- Empty detection: {700, 10, 800, 20} -> {640, 10, 640, 20}, out_empty=1. With RECT_CLAMP_CULL_EN: no output, cull_cnt=1.
- Backpressure: stream of 6 rectangles with out_ready low for cycles 3–7 -> in_ready deasserts once both stages are full, all 6 appear in order, out_rect is stable while stalled, no loss.
- Counter saturation and clear: CNT_W=4, 20 clipped rectangles -> clip_cnt=15. clr_cnt pulsed in the same cycle as a clipped transfer -> clip_cnt=0.
- Async reset: assert rst_n=0 mid-stream with 2 rectangles in flight -> out_valid=0 immediately. After release, no stale rectangle is emitted.
